// File: rtl/user_au_pkg.sv
// Shared types for the user-domain audio DMA.
// OBI bundles follow the user crossbar's 32-bit default layout.
package user_au_pkg;

  localparam int unsigned AuLenWidth = 16;
  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned IdWidth    = 1;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    REQ,
    RSP
  } dma_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  function automatic logic [31:0] sext16(logic [31:0] w);
    logic [31:0] r;
    r = w;
    r[31:16] = {16{w[15]}};
    return r;
  endfunction

endpackage

// File: rtl/user_au_audio_dma_if.sv
// 32-bit valid/ready sample stream between the DMA core
// and its sample FIFOs.
interface user_au_audio_dma_if;

  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/user_au_audio_dma_fifo.sv
// Sample FIFO, power-of-2 depth, synchronous reset and flush.
// Head data reads as zero while empty.
module user_au_audio_dma_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  user_au_audio_dma_if.slave  push,
  user_au_audio_dma_if.master pop
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  logic [31:0]     mem_q [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [PtrW:0]   cnt_q;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign full    = cnt_q == FullCnt;
  assign empty   = cnt_q == '0;
  assign do_pop  = pop.ready & ~empty;
  // a pop frees the slot a same-cycle push lands in
  assign do_push = push.valid & (~full | do_pop);

  assign push.ready = ~full;
  assign pop.valid  = ~empty;
  assign pop.data   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push.data;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_au_audio_dma.sv
// OBI manager moving 16-bit audio samples between memory
// and the effect chain, one outstanding transaction at a time.
module user_au_audio_dma
  import user_au_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [AddrWidth-1:0]  src_addr_i,
  input  logic [AddrWidth-1:0]  dst_addr_i,
  input  logic [AuLenWidth-1:0] len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output obi_req_t              obi_req_o,
  input  obi_rsp_t              obi_rsp_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic [31:0]           data_i,
  input  logic                  valid_i,
  output logic                  ready_o
);

  user_au_audio_dma_if out_push ();
  user_au_audio_dma_if out_pop ();
  user_au_audio_dma_if in_push ();
  user_au_audio_dma_if in_pop ();

  dma_state_e            state_q;
  logic [AuLenWidth-1:0] len_q;
  logic [AuLenWidth-1:0] rd_cnt_q;
  logic [AuLenWidth-1:0] wr_cnt_q;
  logic [AuLenWidth-1:0] acc_cnt_q;
  logic [AddrWidth-1:0]  rd_addr_q;
  logic [AddrWidth-1:0]  wr_addr_q;
  logic                  rd_prio_q;

  logic                  rsp_ok;
  logic                  rsp_err;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  pick_rd;
  logic [AuLenWidth-1:0] rd_cnt_nxt;
  logic [AuLenWidth-1:0] wr_cnt_nxt;

  assign rsp_ok  = state_q == RSP && obi_rsp_i.rvalid
                && !obi_rsp_i.r.err;
  assign rsp_err = state_q == RSP && obi_rsp_i.rvalid
                && obi_rsp_i.r.err;

  assign rd_ok   = rd_cnt_q < len_q && out_push.ready;
  assign wr_ok   = wr_cnt_q < len_q && in_pop.valid;
  assign pick_rd = rd_ok && (!wr_ok || rd_prio_q);

  assign out_push.data  = sext16(obi_rsp_i.r.rdata);
  assign out_push.valid = rsp_ok && !obi_req_o.a.we;
  assign out_pop.ready  = ready_i;
  assign data_o         = out_pop.data;
  assign valid_o        = out_pop.valid;

  assign ready_o       = busy_o && in_push.ready
                      && acc_cnt_q != len_q;
  assign in_push.data  = data_i;
  assign in_push.valid = valid_i && ready_o;
  assign in_pop.ready  = rsp_ok && obi_req_o.a.we;

  assign rd_cnt_nxt = rd_cnt_q + AuLenWidth'(out_push.valid);
  assign wr_cnt_nxt = wr_cnt_q + AuLenWidth'(in_pop.ready);

  user_au_audio_dma_fifo #(
    .Depth (FifoDepth)
  ) i_out_fifo (
    .clk_i,
    .rst_ni,
    .flush_i (rsp_err),
    .push    (out_push),
    .pop     (out_pop)
  );

  user_au_audio_dma_fifo #(
    .Depth (FifoDepth)
  ) i_in_fifo (
    .clk_i,
    .rst_ni,
    .flush_i (rsp_err),
    .push    (in_push),
    .pop     (in_pop)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      acc_cnt_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_prio_q <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      obi_req_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (in_push.valid) begin
        acc_cnt_q <= acc_cnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          busy_o <= 1'b0;
          if (start_i && !busy_o) begin
            len_q     <= len_i;
            rd_addr_q <= src_addr_i;
            wr_addr_q <= dst_addr_i;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            acc_cnt_q <= '0;
            rd_prio_q <= 1'b1;
            err_o     <= 1'b0;
            busy_o    <= 1'b1;
            // empty transfer: one busy cycle carrying done
            if (len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state_q <= ARB;
            end
          end
        end
        ARB: begin
          if (rd_ok || wr_ok) begin
            state_q           <= REQ;
            rd_prio_q         <= !pick_rd;
            obi_req_o.req     <= 1'b1;
            obi_req_o.a.we    <= !pick_rd;
            obi_req_o.a.be    <= 4'hF;
            obi_req_o.a.aid   <= '0;
            obi_req_o.a.addr  <= pick_rd ? rd_addr_q : wr_addr_q;
            obi_req_o.a.wdata <= pick_rd ? '0 : sext16(in_pop.data);
          end
        end
        REQ: begin
          if (obi_rsp_i.gnt) begin
            obi_req_o.req <= 1'b0;
            state_q       <= RSP;
          end
        end
        RSP: begin
          if (rsp_err) begin
            err_o   <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else if (rsp_ok) begin
            rd_cnt_q <= rd_cnt_nxt;
            wr_cnt_q <= wr_cnt_nxt;
            if (obi_req_o.a.we) begin
              wr_addr_q <= wr_addr_q + 32'd4;
            end else begin
              rd_addr_q <= rd_addr_q + 32'd4;
            end
            if (rd_cnt_nxt == len_q && wr_cnt_nxt == len_q) begin
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= ARB;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_au_audio_dma.sv
// Bench for user_au_audio_dma: loopback effect, random-latency
// OBI memory, stream scoreboard and dst-memory checks.
module tb_user_au_audio_dma;
  import user_au_pkg::*;

  typedef struct {
    logic [31:0] src;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        err;
  obi_req_t    req;
  obi_rsp_t    rsp;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic        valid_i;
  logic        ready_o;
  logic        stall = 1'b0;

  always #5 clk = ~clk;

  assign data_i  = data_o;
  assign valid_i = valid_o & ~stall;
  assign ready_i = ready_o & ~stall;

  user_au_audio_dma #(
    .FifoDepth (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .obi_req_o  (req),
    .obi_rsp_i  (rsp),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // memory model: 0-3 cycle gnt and rvalid latency
  logic [31:0] mem [256];
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;
  int          phase = 0;
  int          dly = 0;
  int          rd_seen = 0;
  int          err_at = 0;

  initial begin
    rsp = '0;
    forever begin
      @(posedge clk);
      #2;
      rsp = '0;
      if (!rst_ni) begin
        phase = 0;
      end else if (phase == 1) begin
        if (dly > 0) dly--;
        else begin
          rsp.rvalid = 1'b1;
          if (cap_we) mem[cap_addr[9:2]] = cap_wdata;
          else begin
            rd_seen++;
            rsp.r.rdata = mem[cap_addr[9:2]];
            if (rd_seen == err_at) rsp.r.err = 1'b1;
          end
          phase = 0;
          dly = $urandom_range(0, 3);
        end
      end else if (req.req) begin
        if (dly > 0) dly--;
        else begin
          rsp.gnt = 1'b1;
          cap_addr = req.a.addr;
          cap_we = req.a.we;
          cap_wdata = req.a.wdata;
          phase = 1;
          dly = $urandom_range(0, 3);
        end
      end
    end
  end

  logic [31:0] exp_q [$];
  bit sb_on = 1'b1;
  int done_cnt = 0;
  int req_cyc = 0;
  int rd_done = 0;
  int pops = 0;
  int rd_before_pop = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (req.req) req_cyc++;
    if (valid_o && ready_i) begin
      if (pops == 0) rd_before_pop = rd_done;
      pops++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_extra: got %h expected none", data_o);
        end else begin
          chk("stream_data", data_o, exp_q.pop_front());
        end
      end
    end
    if (rsp.rvalid && !req.a.we) rd_done++;
  end

  vec_t vec [8];

  task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l);
    @(posedge clk);
    #1;
    src = s;
    dst = d;
    len = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int base);
    int n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) begin
      n_chk++;
      $display("FAIL %s: got no done_o expected done_o", nm);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] s, input logic [31:0] d,
                      input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      mem[a[9:2]] = vec[i].src;
      a = d + 32'(4 * i);
      mem[a[9:2]] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_xfer(input string nm, input logic [31:0] s,
                          input logic [31:0] d, input int n,
                          input int stall_cyc);
    int base;
    logic [31:0] a;
    load(s, d, n);
    for (int i = 0; i < n; i++) exp_q.push_back(vec[i].exp);
    base = done_cnt;
    stall = stall_cyc > 0;
    do_start(s, d, 16'(n));
    if (stall_cyc > 0) begin
      repeat (stall_cyc) @(posedge clk);
      #1;
      stall = 1'b0;
    end
    wait_done(nm, base);
    chk({nm, "_done_pulses"}, done_cnt - base, 1);
    chk({nm, "_sb_drained"}, exp_q.size(), 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
    for (int i = 0; i < n; i++) begin
      a = d + 32'(4 * i);
      chk({nm, "_dst"}, mem[a[9:2]], vec[i].exp);
    end
  endtask

  initial begin
    int base;
    int rc;
    int n;
    vec[0] = '{32'h0000_8001, 32'hFFFF_8001};
    vec[1] = '{32'h1234_7FFF, 32'h0000_7FFF};
    vec[2] = '{32'hABCD_0000, 32'h0000_0000};
    vec[3] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    vec[4] = '{32'hFFFF_0001, 32'h0000_0001};
    vec[5] = '{32'h5555_AAAA, 32'hFFFF_AAAA};
    vec[6] = '{32'h7FFF_8000, 32'hFFFF_8000};
    vec[7] = '{32'h8000_7FFE, 32'h0000_7FFE};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_req", req.req, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // basic loopback, then full table across the address wrap
    run_xfer("run1", 32'h0000_0100, 32'h0000_0300, 2, 0);
    run_xfer("table_wrap", 32'hFFFF_FFF0, 32'h0000_0200, 8, 0);

    // backpressure: out FIFO fills to depth, nothing more
    pops = 0;
    rd_done = 0;
    run_xfer("run2", 32'h0000_0080, 32'h0000_0280, 8, 20);
    chk("run2_reads_before_pop_le4", 32'(rd_before_pop <= 4), 1);

    // error on the 3rd read
    sb_on = 1'b0;
    load(32'h0000_0040, 32'h0000_0380, 8);
    rd_seen = 0;
    err_at = 3;
    base = done_cnt;
    do_start(32'h0000_0040, 32'h0000_0380, 16'd8);
    wait_done("run3", base);
    chk("run3_err", err, 1);
    chk("run3_done_pulses", done_cnt - base, 1);
    chk("run3_busy", busy, 0);
    chk("run3_flushed", valid_o, 0);
    rc = req_cyc;
    repeat (20) @(negedge clk);
    chk("run3_req_quiet", req_cyc - rc, 0);
    err_at = 0;
    exp_q.delete();
    sb_on = 1'b1;
    do_start(32'h0, 32'h0, 16'd0);
    @(negedge clk);
    chk("run3_err_cleared", err, 0);
    repeat (3) @(negedge clk);

    // len = 0
    base = done_cnt;
    rc = req_cyc;
    do_start(32'h0000_0040, 32'h0000_0380, 16'd0);
    @(negedge clk);
    chk("run4_done_c1", done, 1);
    chk("run4_busy_c1", busy, 1);
    @(negedge clk);
    chk("run4_done_c2", done, 0);
    chk("run4_busy_c2", busy, 0);
    repeat (5) @(negedge clk);
    chk("run4_done_pulses", done_cnt - base, 1);
    chk("run4_req_cycles", req_cyc - rc, 0);

    // start while busy is ignored
    load(32'h0000_0040, 32'h0000_0100, 4);
    mem[8'h60] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) exp_q.push_back(vec[i].exp);
    base = done_cnt;
    do_start(32'h0000_0040, 32'h0000_0100, 16'd4);
    repeat (2) @(posedge clk);
    do_start(32'h0000_0010, 32'h0000_0180, 16'd1);
    wait_done("run5", base);
    chk("run5_done_pulses", done_cnt - base, 1);
    chk("run5_sb_drained", exp_q.size(), 0);
    chk("run5_other_dst", mem[8'h60], 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("run5_dst", mem[8'h40 + i], vec[i].exp);
    end

    // reset while a request is pending
    sb_on = 1'b0;
    load(32'h0000_0040, 32'h0000_0100, 4);
    stall = 1'b1;
    base = done_cnt;
    do_start(32'h0000_0040, 32'h0000_0100, 16'd4);
    n = 0;
    while (!(req.req && valid_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("run6_reached_req", req.req, 1);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    chk("run6_req", req.req, 0);
    chk("run6_valid", valid_o, 0);
    chk("run6_busy", busy, 0);
    chk("run6_done", done, 0);
    repeat (10) @(negedge clk);
    chk("run6_no_done", done_cnt - base, 0);
    exp_q.delete();
    sb_on = 1'b1;
    run_xfer("run6_after", 32'h0000_0100, 32'h0000_0300, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
